// File: rtl/log_acc_pkg.sv
// Shared types and constants for the Kulisch accumulator read-out decoder.
package log_acc_pkg;

  localparam int unsigned DEF_ACC_DESIRED = 32;
  localparam int unsigned DEF_EXP_OUT     = 4;
  localparam int unsigned DEF_CHUNK       = 8;

  // Negative results encode -2^(e+1), so the exponent drops by one.
  localparam int unsigned NEG_EXP_OFFSET = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABS,
    ST_SCAN,
    ST_PACK,
    ST_DONE
  } state_t;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  // The sign sits directly above the exponent field.
  function automatic int unsigned sign_pos(input int unsigned exp_out);
    return exp_out;
  endfunction

  localparam int unsigned SIGN_POS = sign_pos(DEF_EXP_OUT);

endpackage

// File: rtl/log_acc_decode_if.sv
// Input/output valid-ready bus of the accumulator decoder.
interface log_acc_decode_if #(
  parameter int unsigned ACC_DESIRED = 32,
  parameter int unsigned EXP_OUT     = 4
);

  logic                   in_valid;
  logic                   in_ready;
  logic [ACC_DESIRED-1:0] accIn;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_OUT:0]       out_log;
  logic                   out_zero;
  logic                   out_ovf;
  logic                   out_unf;

  modport master (
    output in_valid, accIn, out_ready,
    input  in_ready, out_valid, out_log, out_zero, out_ovf, out_unf
  );

  modport slave (
    input  in_valid, accIn, out_ready,
    output in_ready, out_valid, out_log, out_zero, out_ovf, out_unf
  );

endinterface

// File: rtl/lead_one_chunk.sv
// Combinational priority encoder: index of the highest set bit in one chunk.
module lead_one_chunk #(
  parameter int unsigned CHUNK = 8,
  localparam int unsigned IW   = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
  input  logic [CHUNK-1:0] bits,
  output logic             any,
  output logic [IW-1:0]    idx
);

  // Ascending scan so the last hit, i.e. the highest one, wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      if (bits[i]) begin
        any = 1'b1;
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/log_acc_decode.sv
// Decodes a two's-complement Kulisch accumulator word into {sign, exponent} log format.
// Build option: define LOG_ACC_DECODE_ROUND_EN for round-half-up instead of truncation.
module log_acc_decode
  import log_acc_pkg::*;
#(
  parameter int unsigned ACC_DESIRED = DEF_ACC_DESIRED,
  parameter int unsigned EXP_OUT     = DEF_EXP_OUT,
  parameter int unsigned CHUNK       = DEF_CHUNK
) (
  input logic             clock,
  input logic             reset,
  log_acc_decode_if.slave bus
);

  localparam int unsigned N_CHUNK  = ceil_div(ACC_DESIRED, CHUNK);
  localparam int unsigned PADW     = N_CHUNK * CHUNK;
  localparam int unsigned PW       = (PADW > 1) ? $clog2(PADW) : 1;
  localparam int unsigned CW       = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
  localparam int unsigned IW       = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  localparam int unsigned EXP_MAX  = (1 << EXP_OUT) - 1;
  localparam int unsigned SIGN_BIT = sign_pos(EXP_OUT);

  state_t                 state;
  logic [ACC_DESIRED-1:0] acc_q;
  logic                   sign_q;
  logic [PADW-1:0]        mag_q;
  logic [PW-1:0]          pos_q;
  logic                   found_q;
  logic [CW-1:0]          cnt_q;

  logic                   out_valid_q;
  logic [EXP_OUT:0]       out_log_q;
  logic                   out_zero_q;
  logic                   out_ovf_q;
  logic                   out_unf_q;

  logic [ACC_DESIRED-1:0] abs_c;
  logic [CW-1:0]          sel_c;
  logic [CHUNK-1:0]       chunk_arr [N_CHUNK];
  logic                   lo_any;
  logic [IW-1:0]          lo_idx;
  logic [31:0]            k_c;
  logic [31:0]            e_c;

  assign abs_c = acc_q[ACC_DESIRED-1] ? (~acc_q + ACC_DESIRED'(1)) : acc_q;
  assign sel_c = CW'(N_CHUNK - 1) - cnt_q;

  for (genvar g = 0; g < N_CHUNK; g++) begin : g_chunk
    assign chunk_arr[g] = mag_q[g*CHUNK +: CHUNK];
  end

  lead_one_chunk #(.CHUNK(CHUNK)) u_lead (
    .bits (chunk_arr[sel_c]),
    .any  (lo_any),
    .idx  (lo_idx)
  );

  // Exponent before saturation; only meaningful in PACK with found_q set.
  always_comb begin
    k_c = 32'(pos_q);
`ifdef LOG_ACC_DECODE_ROUND_EN
    if ((pos_q != '0) && mag_q[pos_q - PW'(1)]) begin
      k_c = k_c + 32'd1;
    end
`endif
    e_c = sign_q ? (k_c - 32'(NEG_EXP_OFFSET)) : k_c;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      acc_q       <= '0;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      pos_q       <= '0;
      found_q     <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_log_q   <= '0;
      out_zero_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            acc_q <= bus.accIn;
            state <= ST_ABS;
          end
        end
        ST_ABS: begin
          sign_q  <= acc_q[ACC_DESIRED-1];
          mag_q   <= PADW'(abs_c);
          pos_q   <= '0;
          found_q <= 1'b0;
          cnt_q   <= '0;
          state   <= ST_SCAN;
        end
        ST_SCAN: begin
          if (!found_q && lo_any) begin
            pos_q   <= PW'(32'(sel_c) * CHUNK + 32'(lo_idx));
            found_q <= 1'b1;
          end
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(N_CHUNK - 1)) begin
            state <= ST_PACK;
          end
        end
        ST_PACK: begin
          out_zero_q <= 1'b0;
          out_ovf_q  <= 1'b0;
          out_unf_q  <= 1'b0;
          out_log_q  <= '0;
          if (!found_q) begin
            out_zero_q <= 1'b1;
          end else if (sign_q && (k_c == 32'd0)) begin
            // -1 would need exponent -1: flush to zero.
            out_zero_q <= 1'b1;
            out_unf_q  <= 1'b1;
          end else if (e_c > 32'(EXP_MAX)) begin
            out_ovf_q                <= 1'b1;
            out_log_q[SIGN_BIT]      <= sign_q;
            out_log_q[EXP_OUT-1:0]   <= EXP_OUT'(EXP_MAX);
          end else begin
            out_log_q[SIGN_BIT]      <= sign_q;
            out_log_q[EXP_OUT-1:0]   <= e_c[EXP_OUT-1:0];
          end
          out_valid_q <= 1'b1;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_log   = out_log_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_unf   = out_unf_q;

endmodule

// File: tb/tb_log_acc_decode.sv
// Scoreboard bench for log_acc_decode: directed vectors, queue-based result checking.
module tb_log_acc_decode;

  localparam int LATENCY = 6;

  typedef struct {
    logic [4:0] lg;
    logic       z;
    logic       o;
    logic       u;
    int         acc_edge;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  exp_t exp_q[$];
  exp_t cur;
  logic prev_v;

  log_acc_decode_if bus ();

  log_acc_decode dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: pops on each new result, then checks it holds while unaccepted.
  always @(negedge clk) begin
    if (bus.out_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        cur = exp_q.pop_front();
        chk("out_log", 32'(bus.out_log), 32'(cur.lg));
        chk("out_zero", 32'(bus.out_zero), 32'(cur.z));
        chk("out_ovf", 32'(bus.out_ovf), 32'(cur.o));
        chk("out_unf", 32'(bus.out_unf), 32'(cur.u));
        chk("latency", 32'(cyc - cur.acc_edge), 32'(LATENCY));
      end
    end else if (bus.out_valid && prev_v) begin
      chk("hold_log", 32'({bus.out_log, bus.out_zero, bus.out_ovf, bus.out_unf}),
          32'({cur.lg, cur.z, cur.o, cur.u}));
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    prev_v = bus.out_valid;
  end

  task automatic send(input logic [31:0] a, input logic [4:0] lg, input logic z,
                      input logic o, input logic u, input int hold);
    exp_t e;
    int   n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_send", 32'(bus.in_ready), 32'd1);
    bus.accIn    = a;
    bus.in_valid = 1'b1;
    e.lg = lg; e.z = z; e.o = o; e.u = u; e.acc_edge = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.accIn    = $urandom;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      chk("out_valid_timeout", 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = i[0];
      bus.accIn    = 32'h0000_0100;
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; total = 0; bad = 0; prev_v = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.accIn = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_log", 32'(bus.out_log), 32'd0);
    chk("rst_flags", 32'({bus.out_zero, bus.out_ovf, bus.out_unf}), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    send(32'h0000_0040, 5'h06, 1'b0, 1'b0, 1'b0, 0);
    send(32'hFFFF_FF80, 5'h16, 1'b0, 1'b0, 1'b0, 0);
    send(32'hFFFF_FFFF, 5'h00, 1'b1, 1'b0, 1'b1, 0);
    send(32'h0000_0000, 5'h00, 1'b1, 1'b0, 1'b0, 0);
    send(32'h0001_0000, 5'h0F, 1'b0, 1'b1, 1'b0, 0);
    send(32'h8000_0000, 5'h1F, 1'b0, 1'b1, 1'b0, 0);
    send(32'h7FFF_FFFF, 5'h0F, 1'b0, 1'b1, 1'b0, 0);
    send(32'hFFFF_FFFE, 5'h10, 1'b0, 1'b0, 1'b0, 0);
`ifdef LOG_ACC_DECODE_ROUND_EN
    send(32'h0000_0060, 5'h07, 1'b0, 1'b0, 1'b0, 0);
    send(32'h0000_C000, 5'h0F, 1'b0, 1'b1, 1'b0, 0);
    send(32'hFFFF_FFFD, 5'h11, 1'b0, 1'b0, 1'b0, 0);
`else
    send(32'h0000_0060, 5'h06, 1'b0, 1'b0, 1'b0, 0);
    send(32'h0000_C000, 5'h0F, 1'b0, 1'b0, 1'b0, 0);
    send(32'hFFFF_FFFD, 5'h10, 1'b0, 1'b0, 1'b0, 0);
`endif
    // Held result with ignored in_valid pulses.
    send(32'h0000_0040, 5'h06, 1'b0, 1'b0, 1'b0, 5);

    // Abort during the second SCAN cycle.
    @(negedge clk);
    bus.accIn    = 32'h0000_0040;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_no_valid", 32'(bus.out_valid), 32'd0);
    end

    send(32'h0000_0001, 5'h00, 1'b0, 1'b0, 1'b0, 0);

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
